// File: rtl/button_debounce_pulse.sv
// Pushbutton conditioner: synchroniser, stable-time debounce FSM, press/release strobes.
// Optional auto-repeat on a held button: define BUTTON_DEBOUNCE_PULSE_AUTO_REPEAT_EN.
module button_debounce_pulse #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

`ifdef BUTTON_DEBOUNCE_PULSE_AUTO_REPEAT_EN
    localparam bit AUTO_REPEAT = 1'b1;
`else
    localparam bit AUTO_REPEAT = 1'b0;
`endif

    generate
        if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 ||
            (AUTO_REPEAT && (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1))) begin : g_param_err
            $error("button_debounce_pulse: illegal parameter value");
        end
    endgenerate

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    logic [SYNC_STAGES-1:0] sync_chain_q;
    logic                   sync_q;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          rpt_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain_q <= '0;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign sync_q  = sync_chain_q[SYNC_STAGES-1];
    assign cnt_inc = cnt_q + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // The RELEASED/PRESSED sample counts as the first stable cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RELEASED: begin
                if (sync_q) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!sync_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (!sync_q) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (sync_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        level_d   = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
        press_d   = ((state_q == WAIT_PRESS) && (state_d == PRESSED)) || rpt_fire;
        release_d = (state_q == WAIT_RELEASE) && (state_d == RELEASED);
    end

`ifdef BUTTON_DEBOUNCE_PULSE_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RW-1:0] RPT_ONE  = RW'(1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_q, rpt_d;
    logic          first_q, first_d;
    logic          rpt_fire_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q   <= '0;
            first_q <= 1'b1;
        end else begin
            rpt_q   <= rpt_d;
            first_q <= first_d;
        end
    end

    // First interval is REPEAT_DELAY, later ones REPEAT_PERIOD.
    always_comb begin
        rpt_d      = rpt_q;
        first_d    = first_q;
        rpt_fire_d = 1'b0;
        if ((state_q == WAIT_PRESS) && (state_d == PRESSED)) begin
            rpt_d   = '0;
            first_d = 1'b1;
        end else if (((state_q == PRESSED) || (state_q == WAIT_RELEASE)) &&
                     (state_d != RELEASED)) begin
            if (rpt_q == (first_q ? DLY_LAST : PER_LAST)) begin
                rpt_fire_d = 1'b1;
                rpt_d      = '0;
                first_d    = 1'b0;
            end else begin
                rpt_d = rpt_q + RPT_ONE;
            end
        end else begin
            rpt_d   = '0;
            first_d = 1'b1;
        end
    end

    assign rpt_fire = rpt_fire_d;
`else
    assign rpt_fire = 1'b0;
`endif

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: doc/button_debounce_pulse.md
Name: button_debounce_pulse

Overview:
Conditions a raw pushbutton before it reaches the up-counter/display chain.
- Synchronises the asynchronous button input to clk.
- Filters contact bounce with a stable-time counter.
- Produces a clean level plus single-cycle press and release strobes, so a physical press steps or enables the counter exactly once.
- Sits directly upstream of the up-counter, in the same clk domain as the BCD converter and display driver.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the input synchroniser chain; legal range is 2 or more.
DEBOUNCE_CYCLES, 1000000, consecutive clk cycles the synchronised input must differ from btn_level before a change is accepted (10 ms at 100 MHz); legal range is 2 or more.
REPEAT_DELAY, 50000000, cycles from the press strobe to the first auto-repeat strobe (used only with AUTO_REPEAT_EN).
REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat strobes (used only with AUTO_REPEAT_EN).

Ports:
clk  input  1  system clock; every flop in the block is clocked on the rising edge.
rst  input  1  asynchronous, active-high reset.
btn_in  input  1  raw button, asynchronous to clk, 1 = pressed.
btn_level  output  1  debounced button state.
btn_press  output  1  one-cycle strobe on an accepted press (and on auto-repeat when enabled).
btn_release  output  1  one-cycle strobe on an accepted release.

Behaviour:
- Reset (rst=1, asynchronous):
  - All synchroniser flops = 0.
  - Stable counter = 0.
  - FSM = RELEASED.
  - btn_level, btn_press and btn_release = 0.
  - The button is treated as released during reset.
- Synchroniser: btn_in passes through SYNC_STAGES flops; only the last stage (sync_q) feeds the logic. No raw btn_in reaches any other logic.
- FSM states and transitions:
  - RELEASED: btn_level=0. If sync_q=1, clear counter and go to WAIT_PRESS.
  - WAIT_PRESS: while sync_q=1, counter increments by 1 per cycle.
    - If sync_q=0 at any cycle (bounce), clear counter and return to RELEASED; no strobe.
    - When counter = DEBOUNCE_CYCLES-1 and sync_q=1: go to PRESSED, set btn_level=1, pulse btn_press for exactly one cycle, clear counter.
  - PRESSED: btn_level=1. If sync_q=0, clear counter and go to WAIT_RELEASE.
  - WAIT_RELEASE: mirror of WAIT_PRESS with sync_q=0.
    - A bounce back to 1 returns to PRESSED with no strobe.
    - On acceptance: go to RELEASED, btn_level=0, one-cycle btn_release.
- Latency: a clean edge on btn_in that is first sampled at rising edge 1 produces btn_press/btn_level=1 immediately after edge SYNC_STAGES+DEBOUNCE_CYCLES. Release latency is identical.
- Counter width: clog2(DEBOUNCE_CYCLES). It never wraps, because it is cleared on acceptance or bounce.
- Strobes:
  - btn_press and btn_release are registered outputs and are never high in the same cycle.
  - Each is high for exactly one clk cycle per event.
- Any glitch shorter than DEBOUNCE_CYCLES produces no output change.
- Reset mid-operation (in WAIT_*, or during a strobe): outputs drop to 0 immediately and the FSM returns to RELEASED.
- Button held through reset deassertion: treated as a new press and reported after the full latency.
- Illegal parameters (SYNC_STAGES<2 or DEBOUNCE_CYCLES<2) are rejected at elaboration by a generate-time error.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_PULSE_AUTO_REPEAT_EN.
- With the macro defined:
  - In PRESSED, a repeat counter starts at the cycle after the press strobe.
  - btn_press pulses again REPEAT_DELAY cycles after the initial strobe, then every REPEAT_PERIOD cycles while the FSM stays in PRESSED.
  - Repeats continue while in WAIT_RELEASE.
  - Once a release is accepted, the repeat counter clears and no further repeats occur.
- Without the macro: exactly one btn_press per accepted press. The repeat counter and its logic are absent, and REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan:
1. SYNC_STAGES=2, DEBOUNCE_CYCLES=4; after reset, set btn_in=1 and hold -> btn_press is high for one cycle and btn_level rises after edge 6; no further strobes.
2. Same params; btn_in pattern 1,1,0,1,1,1,1,1 (one bounce) -> no strobe until 4 consecutive synchronised 1s; exactly one btn_press.
3. Pressed and stable, then btn_in=0 with 2-cycle bounces to 1 -> btn_level stays 1 during the bounces; a single btn_release follows 4 clean 0 cycles.
4. Assert rst asynchronously mid-WAIT_PRESS (counter=2) -> all outputs 0 at once; after release, a held btn_in yields btn_press 6 edges later.
5. 1-cycle and 3-cycle pulses on btn_in -> btn_level, btn_press and btn_release stay 0 throughout.
6. With BUTTON_DEBOUNCE_PULSE_AUTO_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5; hold for 30 cycles after the press -> btn_press at +0, +10, +15, +20, +25, +30; none after release is accepted.
